mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK for a shared-memory datapath.
- Successor to the single-cycle decoder. Keeps the opcode/funct/rotation decode and the ALU op encodings.
- Adds memory-ready stalls, bne and j, parametrised ALU-op width, and illegal-opcode trapping.
- Sits between the instruction register and the datapath muxes, ALU, register file and memory.

Parameters:
- ALU_OP_W, 4, width of aluOp_o; must be ≥4, upper bits zero.
- TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters TRAP; 0 = treat as NOP and return to FETCH.
- ENABLE_ROTR, 1, 0 = rotation_i ignored, funct 000010 always srl.

Ports:
- clk_i, in, 1, clock, rising edge.
- rst_ni, in, 1, asynchronous active-low reset.
- opcode_i, in, 6, IR[31:26].
- funct_i, in, 6, IR[5:0].
- rotation_i, in, 1, IR[21], selects rotr vs srl.
- zero_i, in, 1, ALU zero flag.
- mem_ready_i, in, 1, memory access completes this cycle.
- irWrite_o, out, 1, load instruction register.
- pcWrite_o, out, 1, load PC.
- pcSrc_o, out, 2, PC source: 0 ALU result, 1 ALUOut, 2 jump target.
- iorD_o, out, 1, memory address source: 0 PC, 1 ALUOut.
- memRead_o, out, 1, memory read strobe.
- memWrite_o, out, 1, memory write strobe.
- regDst_o, out, 1, write-register select: 1 rd, 0 rt.
- memToReg_o, out, 1, write-back source: 1 MDR, 0 ALUOut.
- regWrite_o, out, 1, register-file write enable.
- aluSrcA_o, out, 2, ALU A source: 0 PC, 1 rs, 2 shamt.
- aluSrcB_o, out, 2, ALU B source: 0 rt, 1 const 4, 2 sext(imm), 3 sext(imm)<<2.
- aluOp_o, out, ALU_OP_W, ALU operation.
- state_o, out, 4, current state (debug).
- illegal_o, out, 1, set while in TRAP.

Behaviour:
- Reset: async on rst_ni low; state becomes FETCH. While in reset, outputs are the FETCH decode with mem_ready_i forced 0: memRead=1, all others 0.
- Clocking: state register only; outputs decode combinationally from state. irWrite_o and pcWrite_o additionally gate on mem_ready_i or zero_i as listed.
- States and encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, RWB=7, EXEC_I=8, IWB=9, BRANCH=10, JUMP=11, TRAP=12.
- FETCH:
  - Drives iorD=0, memRead=1, A=0, B=1, aluOp=0000.
  - Stays in FETCH while mem_ready_i=0.
  - When mem_ready_i=1: irWrite=1, pcWrite=1, pcSrc=0; next state DECODE.
- DECODE: A=0, B=3, aluOp=0000 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC_R.
  - 100011 and 101011 → MEMADDR.
  - 001000, 001100, 001101, 001010, 001110 → EXEC_I.
  - 000100 and 000101 → BRANCH.
  - 000010 → JUMP.
  - Any other opcode → TRAP if TRAP_ON_ILLEGAL, else FETCH.
- MEMADDR: A=1, B=2, aluOp=0000. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: iorD=1, memRead=1. Holds until mem_ready_i=1, then MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1; next state FETCH.
- MEMWRITE: iorD=1, memWrite=1. Holds until mem_ready_i=1, then FETCH. memWrite_o stays high for the whole stall.
- EXEC_R:
  - funct 000000: A=2, B=0, aluOp=1000 (sll).
  - funct 000010: A=2, B=0, aluOp=1011 if rotation_i and ENABLE_ROTR, else 1001.
  - Any other funct: A=1, B=0, aluOp=0010.
  - Next state RWB.
- RWB: regDst=1, memToReg=0, regWrite=1; next state FETCH.
- EXEC_I: A=1, B=2. aluOp: addi 0011, andi 0100, ori 0101, slti 0110, xori 0111. Next state IWB.
- IWB: regDst=0, memToReg=0, regWrite=1; next state FETCH.
- BRANCH:
  - A=1, B=0, aluOp=0001, pcSrc=1.
  - pcWrite = zero_i for beq, !zero_i for bne.
  - Next state FETCH.
- JUMP: pcSrc=2, pcWrite=1; next state FETCH.
- TRAP: all strobes 0, illegal_o=1. Exited only by reset.
- Latency in cycles, excluding memory stalls: lw 5, sw 4, R-type 4, I-type 4, branch 3, jump 3.
- Opcode and funct are sampled from the IR, which changes only on irWrite_o. Mid-instruction changes on opcode_i are a datapath error and are not guarded.
- Reset mid-stall: the pending strobe drops immediately and the FSM restarts in FETCH.
- Strobe exclusivity: memRead and memWrite are never both 1, and regWrite and memWrite are never both 1.
- Any unused state encoding (13–15) returns to FETCH on the next clock.

Decomposition:
- Package mc_pkg holds:
  - state enum and its encodings;
  - opcode constants (R, ADDI, ANDI, ORI, SLTI, XORI, LW, SW, BEQ, BNE, J);
  - funct constants (SLL, SRL);
  - ALU op constants;
  - aluSrcA/aluSrcB/pcSrc select codes.
- One sub-module, mc_alu_decode: combinational state + opcode/funct/rotation → aluOp, aluSrcA, aluSrcB. Shared with the single-cycle path.

Test Plan:
- Reset with rst_ni=0 mid-MEMREAD → state_o=0 and memRead_o=1 asynchronously, before the next clock edge; regWrite_o=0.
- lw (opcode 100011), mem_ready_i low for 3 cycles in MEMREAD → state sequence 0,1,2,3,3,3,3,4,0; regWrite_o=1 only in MEMWB with memToReg_o=1.
- R-type funct 000010 with rotation_i=1 → aluOp_o=1011 in EXEC_R with ENABLE_ROTR=1, and 1001 with ENABLE_ROTR=0; aluSrcA_o=2.
- beq with zero_i=1 → pcWrite_o=1, pcSrc_o=1 in BRANCH. bne with zero_i=1 → pcWrite_o=0. Each takes 3 cycles.
- Opcode 111111 → TRAP with illegal_o=1, held for 10 cycles. With TRAP_ON_ILLEGAL=0 → returns to FETCH after DECODE.
- FETCH with mem_ready_i=0 for 5 cycles → irWrite_o and pcWrite_o stay 0; they pulse for exactly one cycle when mem_ready_i=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM states,
// instruction field constants, ALU op codes and datapath mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADDR  = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_RWB      = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_IWB      = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_ADDI  = 4'b0011;
  localparam logic [3:0] ALU_ANDI  = 4'b0100;
  localparam logic [3:0] ALU_ORI   = 4'b0101;
  localparam logic [3:0] ALU_SLTI  = 4'b0110;
  localparam logic [3:0] ALU_XORI  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_ROTR  = 4'b1011;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_SLTI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU control: state plus opcode/funct/rotation select the
// ALU operation and both ALU operand sources.
module mc_alu_decode
  import mc_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 4,
  parameter bit          ENABLE_ROTR = 1'b1
) (
  input  state_e              state_i,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  input  logic                rotation_i,
  output logic [ALU_OP_W-1:0] aluOp_o,
  output logic [1:0]          aluSrcA_o,
  output logic [1:0]          aluSrcB_o
);

  logic [3:0] op_raw;

  always_comb begin
    op_raw    = ALU_ADD;
    aluSrcA_o = SRCA_PC;
    aluSrcB_o = SRCB_RT;
    case (state_i)
      ST_FETCH: begin
        aluSrcB_o = SRCB_FOUR;
      end
      ST_DECODE: begin
        // Speculative branch target lands in ALUOut before the opcode is known.
        aluSrcB_o = SRCB_IMM_SH;
      end
      ST_MEMADDR: begin
        aluSrcA_o = SRCA_RS;
        aluSrcB_o = SRCB_IMM;
      end
      ST_EXEC_R: begin
        case (funct_i)
          FN_SLL: begin
            aluSrcA_o = SRCA_SHAMT;
            op_raw    = ALU_SLL;
          end
          FN_SRL: begin
            aluSrcA_o = SRCA_SHAMT;
            op_raw    = (ENABLE_ROTR && rotation_i) ? ALU_ROTR : ALU_SRL;
          end
          default: begin
            aluSrcA_o = SRCA_RS;
            op_raw    = ALU_RTYPE;
          end
        endcase
      end
      ST_EXEC_I: begin
        aluSrcA_o = SRCA_RS;
        aluSrcB_o = SRCB_IMM;
        case (opcode_i)
          OP_ADDI: op_raw = ALU_ADDI;
          OP_ANDI: op_raw = ALU_ANDI;
          OP_ORI:  op_raw = ALU_ORI;
          OP_SLTI: op_raw = ALU_SLTI;
          OP_XORI: op_raw = ALU_XORI;
          default: op_raw = ALU_ADD;
        endcase
      end
      ST_BRANCH: begin
        aluSrcA_o = SRCA_RS;
        op_raw    = ALU_SUB;
      end
      default: begin
        op_raw = ALU_ADD;
      end
    endcase
  end

  assign aluOp_o = ALU_OP_W'(op_raw);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM with memory-ready stalls,
// branch/jump sequencing and illegal-opcode trapping.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned ALU_OP_W        = 4,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter bit          ENABLE_ROTR     = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  input  logic                rotation_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                irWrite_o,
  output logic                pcWrite_o,
  output logic [1:0]          pcSrc_o,
  output logic                iorD_o,
  output logic                memRead_o,
  output logic                memWrite_o,
  output logic                regDst_o,
  output logic                memToReg_o,
  output logic                regWrite_o,
  output logic [1:0]          aluSrcA_o,
  output logic [1:0]          aluSrcB_o,
  output logic [ALU_OP_W-1:0] aluOp_o,
  output logic [3:0]          state_o,
  output logic                illegal_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode_i == OP_R)                              state_d = ST_EXEC_R;
        else if (opcode_i == OP_LW || opcode_i == OP_SW)   state_d = ST_MEMADDR;
        else if (is_itype(opcode_i))                       state_d = ST_EXEC_I;
        else if (opcode_i == OP_BEQ || opcode_i == OP_BNE) state_d = ST_BRANCH;
        else if (opcode_i == OP_J)                         state_d = ST_JUMP;
        else state_d = TRAP_ON_ILLEGAL ? ST_TRAP : ST_FETCH;
      end
      ST_MEMADDR:  state_d = (opcode_i == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_ready_i) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (mem_ready_i) state_d = ST_FETCH;
      ST_EXEC_R:   state_d = ST_RWB;
      ST_RWB:      state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_IWB;
      ST_IWB:      state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    irWrite_o  = 1'b0;
    pcWrite_o  = 1'b0;
    pcSrc_o    = PCSRC_ALU;
    iorD_o     = 1'b0;
    memRead_o  = 1'b0;
    memWrite_o = 1'b0;
    regDst_o   = 1'b0;
    memToReg_o = 1'b0;
    regWrite_o = 1'b0;
    illegal_o  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memRead_o = 1'b1;
        // Held reset masks mem_ready so no spurious IR/PC load escapes.
        irWrite_o = mem_ready_i & rst_ni;
        pcWrite_o = mem_ready_i & rst_ni;
      end
      ST_MEMREAD: begin
        iorD_o    = 1'b1;
        memRead_o = 1'b1;
      end
      ST_MEMWB: begin
        memToReg_o = 1'b1;
        regWrite_o = 1'b1;
      end
      ST_MEMWRITE: begin
        iorD_o     = 1'b1;
        memWrite_o = 1'b1;
      end
      ST_RWB: begin
        regDst_o   = 1'b1;
        regWrite_o = 1'b1;
      end
      ST_IWB: begin
        regWrite_o = 1'b1;
      end
      ST_BRANCH: begin
        pcSrc_o   = PCSRC_ALUOUT;
        pcWrite_o = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
      end
      ST_JUMP: begin
        pcSrc_o   = PCSRC_JUMP;
        pcWrite_o = 1'b1;
      end
      ST_TRAP: begin
        illegal_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b0;
      end
    endcase
  end

  mc_alu_decode #(
    .ALU_OP_W    (ALU_OP_W),
    .ENABLE_ROTR (ENABLE_ROTR)
  ) u_alu_decode (
    .state_i    (state_q),
    .opcode_i   (opcode_i),
    .funct_i    (funct_i),
    .rotation_i (rotation_i),
    .aluOp_o    (aluOp_o),
    .aluSrcA_o  (aluSrcA_o),
    .aluSrcB_o  (aluSrcB_o)
  );

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized instruction-level bench for mc_control: three parameter
// variants share stimulus and are checked every cycle against a phase model.
module tb_mc_control;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADDR = 2, P_MEMREAD = 3,
                 P_MEMWB = 4, P_MEMWRITE = 5, P_EXEC_R = 6, P_RWB = 7,
                 P_EXEC_I = 8, P_IWB = 9, P_BRANCH = 10, P_JUMP = 11,
                 P_TRAP = 12;

  localparam logic [5:0] LEGAL_OPS [11] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C,
                                            6'h0D, 6'h0A, 6'h0E, 6'h04, 6'h05,
                                            6'h02};

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [5:0] opcode_i, funct_i;
  logic       rotation_i, zero_i, mem_ready_i;

  logic       irw [3], pcw [3], iord [3], mrd [3], mwr [3];
  logic       rdst [3], m2r [3], rwr [3], ill [3];
  logic [1:0] pcs [3], sa [3], sb [3];
  logic [3:0] st [3];
  logic [3:0] alu_a, alu_c;
  logic [5:0] alu_b;

  int total = 0;
  int bad   = 0;
  int zmode = -1;

  always #5 clk_i = ~clk_i;

  mc_control #(.ALU_OP_W(4), .TRAP_ON_ILLEGAL(1'b1), .ENABLE_ROTR(1'b1)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct_i(funct_i),
    .rotation_i(rotation_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .irWrite_o(irw[0]), .pcWrite_o(pcw[0]), .pcSrc_o(pcs[0]), .iorD_o(iord[0]),
    .memRead_o(mrd[0]), .memWrite_o(mwr[0]), .regDst_o(rdst[0]),
    .memToReg_o(m2r[0]), .regWrite_o(rwr[0]), .aluSrcA_o(sa[0]),
    .aluSrcB_o(sb[0]), .aluOp_o(alu_a), .state_o(st[0]), .illegal_o(ill[0]));

  mc_control #(.ALU_OP_W(6), .TRAP_ON_ILLEGAL(1'b1), .ENABLE_ROTR(1'b0)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct_i(funct_i),
    .rotation_i(rotation_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .irWrite_o(irw[1]), .pcWrite_o(pcw[1]), .pcSrc_o(pcs[1]), .iorD_o(iord[1]),
    .memRead_o(mrd[1]), .memWrite_o(mwr[1]), .regDst_o(rdst[1]),
    .memToReg_o(m2r[1]), .regWrite_o(rwr[1]), .aluSrcA_o(sa[1]),
    .aluSrcB_o(sb[1]), .aluOp_o(alu_b), .state_o(st[1]), .illegal_o(ill[1]));

  mc_control #(.ALU_OP_W(4), .TRAP_ON_ILLEGAL(1'b0), .ENABLE_ROTR(1'b1)) u_dut_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct_i(funct_i),
    .rotation_i(rotation_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .irWrite_o(irw[2]), .pcWrite_o(pcw[2]), .pcSrc_o(pcs[2]), .iorD_o(iord[2]),
    .memRead_o(mrd[2]), .memWrite_o(mwr[2]), .regDst_o(rdst[2]),
    .memToReg_o(m2r[2]), .regWrite_o(rwr[2]), .aluSrcA_o(sa[2]),
    .aluSrcB_o(sb[2]), .aluOp_o(alu_c), .state_o(st[2]), .illegal_o(ill[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int cls(input logic [5:0] op);
    case (op)
      6'h00:                             return 0;
      6'h23:                             return 1;
      6'h2B:                             return 2;
      6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0E: return 3;
      6'h04, 6'h05:                      return 4;
      6'h02:                             return 5;
      default:                           return 6;
    endcase
  endfunction

  function automatic logic rnd();
    return ($urandom_range(0, 1) != 0);
  endfunction

  // Control word order: irWrite pcWrite pcSrc iorD memRead memWrite regDst memToReg regWrite A B illegal
  function automatic logic [14:0] obs_ctl(input int i);
    return {irw[i], pcw[i], pcs[i], iord[i], mrd[i], mwr[i], rdst[i], m2r[i],
            rwr[i], sa[i], sb[i], ill[i]};
  endfunction

  function automatic logic [31:0] obs_alu(input int i);
    if (i == 0) return 32'(alu_a);
    if (i == 1) return 32'(alu_b);
    return 32'(alu_c);
  endfunction

  function automatic logic [14:0] exp_ctl(input int ph, input logic rdy, input logic z,
                                          input logic [5:0] op, input logic [5:0] fn);
    logic e_irw = 1'b0, e_pcw = 1'b0, e_iord = 1'b0, e_mrd = 1'b0, e_mwr = 1'b0;
    logic e_rdst = 1'b0, e_m2r = 1'b0, e_rwr = 1'b0, e_ill = 1'b0;
    logic [1:0] e_pcs = 2'd0, e_sa = 2'd0, e_sb = 2'd0;
    case (ph)
      P_FETCH:    begin e_mrd = 1'b1; e_sb = 2'd1; e_irw = rdy; e_pcw = rdy; end
      P_DECODE:   e_sb = 2'd3;
      P_MEMADDR:  begin e_sa = 2'd1; e_sb = 2'd2; end
      P_MEMREAD:  begin e_iord = 1'b1; e_mrd = 1'b1; end
      P_MEMWB:    begin e_m2r = 1'b1; e_rwr = 1'b1; end
      P_MEMWRITE: begin e_iord = 1'b1; e_mwr = 1'b1; end
      P_EXEC_R:   e_sa = (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd1;
      P_RWB:      begin e_rdst = 1'b1; e_rwr = 1'b1; end
      P_EXEC_I:   begin e_sa = 2'd1; e_sb = 2'd2; end
      P_IWB:      e_rwr = 1'b1;
      P_BRANCH:   begin e_sa = 2'd1; e_pcs = 2'd1; e_pcw = (op == 6'h05) ? !z : z; end
      P_JUMP:     begin e_pcs = 2'd2; e_pcw = 1'b1; end
      P_TRAP:     e_ill = 1'b1;
      default:    e_ill = 1'b0;
    endcase
    return {e_irw, e_pcw, e_pcs, e_iord, e_mrd, e_mwr, e_rdst, e_m2r, e_rwr,
            e_sa, e_sb, e_ill};
  endfunction

  function automatic logic [31:0] exp_alu(input int ph, input logic [5:0] op,
                                          input logic [5:0] fn, input logic rot,
                                          input logic rotr_en);
    if (ph == P_BRANCH) return 32'd1;
    if (ph == P_EXEC_R) begin
      if (fn == 6'h00) return 32'd8;
      if (fn == 6'h02) return (rot && rotr_en) ? 32'd11 : 32'd9;
      return 32'd2;
    end
    if (ph == P_EXEC_I) begin
      case (op)
        6'h08:   return 32'd3;
        6'h0C:   return 32'd4;
        6'h0D:   return 32'd5;
        6'h0A:   return 32'd6;
        6'h0E:   return 32'd7;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  task automatic check_dut(input int i, input int ph, input logic rdy, input logic z);
    check($sformatf("state[%0d]", i), 32'(st[i]), 32'(ph));
    check($sformatf("ctl[%0d] ph%0d", i, ph), 32'(obs_ctl(i)),
          32'(exp_ctl(ph, rdy, z, opcode_i, funct_i)));
    check($sformatf("aluop[%0d] ph%0d", i, ph), obs_alu(i),
          exp_alu(ph, opcode_i, funct_i, rotation_i, (i != 1)));
  endtask

  // Entered just after a falling edge; leaves just after the next one.
  task automatic cycle(input int ph_ab, input int ph_c, input logic rdy);
    logic z;
    z = (zmode < 0) ? rnd() : zmode[0];
    mem_ready_i = rdy;
    zero_i      = z;
    #1;
    for (int i = 0; i < 3; i++) check_dut(i, (i == 2) ? ph_c : ph_ab, rdy, z);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    mem_ready_i = 1'b1;
    zero_i      = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check_dut(i, P_FETCH, 1'b0, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) check_dut(i, P_FETCH, 1'b0, 1'b1);
    rst_ni = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic rot,
                           input int sf, input int sm, input int zm);
    opcode_i   = op;
    funct_i    = fn;
    rotation_i = rot;
    zmode      = zm;
    repeat (sf) cycle(P_FETCH, P_FETCH, 1'b0);
    cycle(P_FETCH, P_FETCH, 1'b1);
    cycle(P_DECODE, P_DECODE, rnd());
    case (cls(op))
      0: begin cycle(P_EXEC_R, P_EXEC_R, rnd()); cycle(P_RWB, P_RWB, rnd()); end
      1: begin
        cycle(P_MEMADDR, P_MEMADDR, rnd());
        repeat (sm) cycle(P_MEMREAD, P_MEMREAD, 1'b0);
        cycle(P_MEMREAD, P_MEMREAD, 1'b1);
        cycle(P_MEMWB, P_MEMWB, rnd());
      end
      2: begin
        cycle(P_MEMADDR, P_MEMADDR, rnd());
        repeat (sm) cycle(P_MEMWRITE, P_MEMWRITE, 1'b0);
        cycle(P_MEMWRITE, P_MEMWRITE, 1'b1);
      end
      3: begin cycle(P_EXEC_I, P_EXEC_I, rnd()); cycle(P_IWB, P_IWB, rnd()); end
      4: cycle(P_BRANCH, P_BRANCH, rnd());
      5: cycle(P_JUMP, P_JUMP, rnd());
      default: begin
        repeat (10) cycle(P_TRAP, P_FETCH, 1'b0);
        do_reset();
      end
    endcase
  endtask

  logic [5:0] r_op, r_fn;
  int         r_k;

  initial begin
    rst_ni = 1'b0; opcode_i = '0; funct_i = '0; rotation_i = 1'b0;
    zero_i = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk_i);
    do_reset();

    run_instr(6'h23, 6'h00, 1'b0, 0, 3, -1);
    run_instr(6'h00, 6'h02, 1'b1, 0, 0, -1);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, 1);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, 1);
    run_instr(6'h2B, 6'h00, 1'b0, 1, 2, -1);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h08, 6'h00, 1'b0, 5, 0, -1);

    opcode_i = 6'h23; zmode = -1;
    cycle(P_FETCH, P_FETCH, 1'b1);
    cycle(P_DECODE, P_DECODE, rnd());
    cycle(P_MEMADDR, P_MEMADDR, rnd());
    cycle(P_MEMREAD, P_MEMREAD, 1'b0);
    cycle(P_MEMREAD, P_MEMREAD, 1'b0);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      r_k = $urandom_range(0, 11);
      if (r_k == 11) begin
        do r_op = 6'($urandom); while (cls(r_op) != 6);
      end else begin
        r_op = LEGAL_OPS[r_k];
      end
      case ($urandom_range(0, 2))
        0:       r_fn = 6'h00;
        1:       r_fn = 6'h02;
        default: r_fn = 6'($urandom);
      endcase
      run_instr(r_op, r_fn, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
